eeprom_microwire: RTL and testbench

- Serial back end of the EEPROM register block.
- Takes a command word and data word already assembled in the SerialCom/SerialData registers, plus an operation class.
- Drives a physical 93Cx6-style Microwire EEPROM on CS/SK/DI/DO.
- Returns read data, a busy flag and a completion pulse, which the register block reflects into SerialCtrl status bits.

---
 rtl/eeprom_pkg.sv | 30 +++
 rtl/eeprom_mw_tick.sv | 35 +++
 rtl/eeprom_microwire.sv | 160 ++++++++++++++++
 tb/tb_eeprom_microwire.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - shared types and helpers for the Microwire EEPROM engine
package eeprom_pkg;

    typedef enum logic [1:0] {
        OP_SHORT = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_ERASE = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WROUT,
        ST_RDIN,
        ST_GAP,
        ST_POLL,
        ST_FIN
    } state_t;

    // Address width of the attached part; size code 3 is treated like 2.
    function automatic logic [4:0] addr_bits(input logic [1:0] size);
        case (size)
            2'd0:    addr_bits = 5'd6;
            2'd1:    addr_bits = 5'd8;
            default: addr_bits = 5'd10;
        endcase
    endfunction

endpackage

// File: rtl/eeprom_mw_tick.sv
// rtl/eeprom_mw_tick.sv - SK half-period divider with phase and sample strobes
module eeprom_mw_tick #(
    parameter int SK_HALF = 4
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    output logic o_half_end,
    output logic o_bit_end,
    output logic o_sk
);
    localparam int CW = (SK_HALF > 1) ? $clog2(SK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(SK_HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;

    // Count SClk cycles within a half period; disabled means parked at the start of a low phase.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || !i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_half_end = i_en && (r_cnt == LAST);
    assign o_bit_end  = o_half_end && r_phase;
    assign o_sk       = r_phase;

endmodule

// File: rtl/eeprom_microwire.sv
// rtl/eeprom_microwire.sv - Microwire serial engine for the EEPROM register block
module eeprom_microwire
    import eeprom_pkg::*;
#(
    parameter int SK_HALF       = 4,
    parameter int TIMEOUT_POLLS = 4096
) (
    input  logic        SClk,
    input  logic        nRst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [1:0]  EEPROMSize,
    input  logic [15:0] Command,
    input  logic [15:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [15:0] ReadData,
    output logic        EepCS,
    output logic        EepSK,
    output logic        EepDI,
    input  logic        EepDO
);
    localparam int PW = $clog2(TIMEOUT_POLLS + 1);
    localparam int GW = $clog2(2 * SK_HALF + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(TIMEOUT_POLLS - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(2 * SK_HALF - 1);

    state_t        r_state, w_next;
    op_t           r_op;
    logic [15:0]   r_sh, r_wdata, r_rdata;
    logic [4:0]    r_n, r_bits;
    logic [PW-1:0] r_poll;
    logic [GW-1:0] r_gap;
    logic          r_err;
    logic          w_tick_en, w_half_end, w_bit_end, w_sk, w_cmd_live, w_last_bit;

    // CMD holds CS low until the inter-operation CS-low minimum has elapsed.
    assign w_cmd_live = (r_state == ST_CMD) && (r_gap == '0);
    assign w_tick_en  = w_cmd_live || (r_state inside {ST_WROUT, ST_RDIN, ST_GAP, ST_POLL});
    assign w_last_bit = (r_state == ST_CMD) ? (r_bits == r_n - 5'd1) : (r_bits == 5'd15);

    eeprom_mw_tick #(.SK_HALF(SK_HALF)) u_tick (
        .i_clk      (SClk),
        .i_rstn     (nRst),
        .i_en       (w_tick_en),
        .o_half_end (w_half_end),
        .o_bit_end  (w_bit_end),
        .o_sk       (w_sk)
    );

    // Next-state selection and pin decode from the current state.
    always_comb begin
        w_next = r_state;
        Busy   = 1'b0;
        Done   = 1'b0;
        EepCS  = 1'b0;
        EepSK  = 1'b0;
        EepDI  = 1'b0;
        case (r_state)
            ST_IDLE: if (Start) w_next = ST_CMD;
            ST_CMD: begin
                Busy  = 1'b1;
                EepCS = w_cmd_live;
                EepSK = w_sk;
                EepDI = w_cmd_live && r_sh[15];
                if (w_bit_end && w_last_bit) begin
                    case (r_op)
                        OP_READ:  w_next = ST_RDIN;
                        OP_WRITE: w_next = ST_WROUT;
                        OP_SHORT: w_next = ST_FIN;
                        default:  w_next = ST_GAP;
                    endcase
                end
            end
            ST_WROUT: begin
                Busy  = 1'b1;
                EepCS = 1'b1;
                EepSK = w_sk;
                EepDI = r_sh[15];
                if (w_bit_end && w_last_bit) w_next = ST_GAP;
            end
            ST_RDIN: begin
                Busy  = 1'b1;
                EepCS = 1'b1;
                EepSK = w_sk;
                if (w_bit_end && w_last_bit) w_next = ST_FIN;
            end
            ST_GAP: begin
                Busy = 1'b1;
                if (w_bit_end) w_next = ST_POLL;
            end
            ST_POLL: begin
                Busy  = 1'b1;
                EepCS = 1'b1;
                if (w_half_end && (EepDO || r_poll == POLL_LAST)) w_next = ST_FIN;
            end
            ST_FIN: begin
                Done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, shifter, counters and status.
    always_ff @(posedge SClk) begin
        if (!nRst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_SHORT;
            r_sh    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_n     <= '0;
            r_bits  <= '0;
            r_poll  <= '0;
            r_gap   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_gap != '0) r_gap <= r_gap - GW'(1);
            case (r_state)
                ST_IDLE: if (Start) begin
                    r_op    <= op_t'(Op);
                    r_n     <= addr_bits(EEPROMSize) + 5'd3;
                    // Left-align the command so bits above N-1 fall off the top.
                    r_sh    <= Command << (5'd13 - addr_bits(EEPROMSize));
                    r_wdata <= WriteData;
                    r_bits  <= '0;
                    r_poll  <= '0;
                    r_err   <= 1'b0;
                end
                ST_CMD: if (w_bit_end) begin
                    if (w_last_bit) begin
                        r_bits <= '0;
                        r_sh   <= r_wdata;
                    end else begin
                        r_bits <= r_bits + 5'd1;
                        r_sh   <= {r_sh[14:0], 1'b0};
                    end
                end
                ST_WROUT, ST_RDIN: if (w_bit_end) begin
                    r_bits <= r_bits + 5'd1;
                    r_sh   <= {r_sh[14:0], (r_state == ST_RDIN) && EepDO};
                    if (r_state == ST_RDIN && w_last_bit) r_rdata <= {r_sh[14:0], EepDO};
                end
                ST_POLL: if (w_half_end && !EepDO) begin
                    r_poll <= r_poll + PW'(1);
                    if (r_poll == POLL_LAST) r_err <= 1'b1;
                end
                ST_FIN: r_gap <= GAP_LOAD;
                default: ;
            endcase
        end
    end

    assign Error    = r_err;
    assign ReadData = r_rdata;

endmodule

// File: tb/tb_eeprom_microwire.sv
// tb/tb_eeprom_microwire.sv - self-checking bench for eeprom_microwire
module tb_eeprom_microwire;
    localparam int SKH = 2;
    localparam int TP  = 12;

    logic        SClk = 1'b0;
    logic        nRst = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'd0;
    logic [1:0]  EEPROMSize = 2'd0;
    logic [15:0] Command = 16'h0;
    logic [15:0] WriteData = 16'h0;
    logic        Busy, Done, Error, EepCS, EepSK, EepDI;
    logic [15:0] ReadData;
    logic        EepDO = 1'b0;

    eeprom_microwire #(.SK_HALF(SKH), .TIMEOUT_POLLS(TP)) dut (
        .SClk(SClk), .nRst(nRst), .Start(Start), .Op(Op), .EEPROMSize(EEPROMSize),
        .Command(Command), .WriteData(WriteData), .Busy(Busy), .Done(Done),
        .Error(Error), .ReadData(ReadData), .EepCS(EepCS), .EepSK(EepSK),
        .EepDI(EepDI), .EepDO(EepDO)
    );

    always #5 SClk = ~SClk;

    typedef struct packed {
        logic        cs, sk, di, busy, done, err;
        logic [15:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_rd = 16'h0;
    logic        exp_err = 1'b0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = -1;

    int          dev_op = 0, dev_n = 0, dev_polls = -1, dev_pulses = 0, dev_phase = 0, dev_cnt = 0;
    logic [15:0] dev_data = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge SClk);
        cyc++;
    end

    // Per-cycle comparison against the expected waveform; idle expectations when no op is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge SClk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pins", {EepCS, EepSK, EepDI, Busy, Done, Error}, {e.cs, e.sk, e.di, e.busy, e.done, e.err});
                chk("rdata", ReadData, e.rd);
                if (Done) done_cyc = cyc;
            end else begin
                chk("idle_pins", {EepCS, EepSK, EepDI, Busy, Done, Error}, {5'b00000, exp_err});
                chk("idle_rdata", ReadData, exp_rd);
            end
        end
    end

    // 93Cx6 device model: read data after the dummy zero, busy/ready on DO after a write/erase.
    initial begin
        logic pcs, psk;
        pcs = 1'b0;
        psk = 1'b0;
        forever begin
            @(posedge SClk);
            #1;
            if (EepCS && !pcs) begin
                dev_cnt = 0;
                EepDO = (dev_phase == 1 && dev_polls == 0);
            end else if (EepCS && dev_phase == 1) begin
                dev_cnt++;
                if (dev_polls >= 0 && dev_cnt == dev_polls * SKH) EepDO = 1'b1;
            end
            if (EepCS && EepSK && !psk) begin
                dev_pulses++;
                if (dev_op == 1) begin
                    if (dev_pulses > dev_n && dev_pulses <= dev_n + 16)
                        EepDO = dev_data[15 - (dev_pulses - dev_n - 1)];
                    else
                        EepDO = 1'b0;
                end
            end
            if (!EepCS && pcs) begin
                EepDO = 1'b0;
                dev_phase = (dev_phase == 0 && (dev_op == 2 || dev_op == 3)) ? 1 : 0;
            end
            pcs = EepCS;
            psk = EepSK;
        end
    end

    task automatic push_bit(input exp_t base, input logic b);
        exp_t e;
        e = base;
        e.di = b;
        e.sk = 1'b0;
        repeat (SKH) exp_q.push_back(e);
        e.sk = 1'b1;
        repeat (SKH) exp_q.push_back(e);
    endtask

    // polls: zero samples the device answers before ready; -1 means never ready.
    task automatic do_start(input logic [1:0] op, input logic [1:0] size, input logic [15:0] cmd,
                            input logic [15:0] wd, input logic [15:0] ddata, input int polls);
        int          n, k;
        logic [15:0] new_rd;
        logic        new_err;
        exp_t        e;
        n = (size == 2'd0) ? 9 : (size == 2'd1) ? 11 : 13;
        @(negedge SClk);
        Op = op; EEPROMSize = size; Command = cmd; WriteData = wd; Start = 1'b1;
        dev_op = op; dev_n = n; dev_data = ddata; dev_polls = polls; dev_pulses = 0; dev_phase = 0;
        @(posedge SClk);
        #1;
        Start = 1'b0;
        start_cyc = cyc;
        done_cyc = -1;
        e = '{cs: 1'b1, sk: 1'b0, di: 1'b0, busy: 1'b1, done: 1'b0, err: 1'b0, rd: exp_rd};
        for (int i = n - 1; i >= 0; i--) push_bit(e, cmd[i]);
        if (op == 2'd2) for (int i = 15; i >= 0; i--) push_bit(e, wd[i]);
        if (op == 2'd1) for (int i = 0; i < 16; i++) push_bit(e, 1'b0);
        new_rd  = (op == 2'd1) ? ddata : exp_rd;
        new_err = 1'b0;
        if (op >= 2'd2) begin
            e.cs = 1'b0; e.sk = 1'b0; e.di = 1'b0;
            repeat (2 * SKH) exp_q.push_back(e);
            e.cs = 1'b1;
            if (polls >= 0 && polls < TP) k = polls + 1;
            else begin
                k = TP;
                new_err = 1'b1;
            end
            repeat (k * SKH) exp_q.push_back(e);
        end
        e = '{cs: 1'b0, sk: 1'b0, di: 1'b0, busy: 1'b0, done: 1'b1, err: new_err, rd: new_rd};
        exp_q.push_back(e);
        exp_rd  = new_rd;
        exp_err = new_err;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 2000) begin
            @(negedge SClk);
            t++;
        end
        chk("op_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (2 * SKH + 2) @(negedge SClk);
    endtask

    initial begin
        repeat (3) @(negedge SClk);
        chk("rst_outputs", {EepCS, EepSK, EepDI, Busy, Done, Error, ReadData}, 0);
        nRst = 1'b1;
        repeat (3) @(negedge SClk);

        // Read, size 0, addr 3; a Start during the op must be ignored.
        do_start(2'd1, 2'd0, 16'h0183, 16'h0000, 16'hABBA, -1);
        repeat (10) @(negedge SClk);
        Op = 2'd0; Command = 16'hFFFF; Start = 1'b1;
        @(negedge SClk);
        Start = 1'b0;
        wait_idle();
        chk("read_data", ReadData, 16'hABBA);
        chk("read_pulses", dev_pulses, 25);
        chk("read_err", Error, 0);

        // Write 0x1234, device busy for 10 polls.
        do_start(2'd2, 2'd0, 16'h0143, 16'h1234, 16'h0000, 10);
        wait_idle();
        chk("write_pulses", dev_pulses, 25);
        chk("write_err", Error, 0);

        // EWEN: 9 pulses, Done in cycle 38 counting the Start cycle as 1.
        do_start(2'd0, 2'd0, 16'h0130, 16'h0000, 16'h0000, -1);
        wait_idle();
        chk("ewen_latency", done_cyc - start_cyc, 36);
        chk("ewen_pulses", dev_pulses, 9);
        chk("ewen_rdata", ReadData, 16'hABBA);

        // Command bits above N-1 are don't-care.
        do_start(2'd0, 2'd0, 16'hFF30, 16'h0000, 16'h0000, -1);
        wait_idle();
        chk("ewen_hi_latency", done_cyc - start_cyc, 36);

        // Erase with DO stuck low: timeout after TP polls.
        do_start(2'd3, 2'd0, 16'h01C3, 16'h0000, 16'h0000, -1);
        wait_idle();
        chk("erase_timeout_err", Error, 1);
        chk("erase_timeout_latency", done_cyc - start_cyc, 9 * 2 * SKH + 2 * SKH + TP * SKH);

        // Next Start clears Error; ready on the last allowed poll is still a success.
        do_start(2'd2, 2'd0, 16'h0155, 16'hF00F, 16'h0000, TP - 1);
        wait_idle();
        chk("last_poll_err", Error, 0);

        // Erase with immediate ready.
        do_start(2'd3, 2'd1, 16'h07FF, 16'h0000, 16'h0000, 0);
        wait_idle();
        chk("erase_fast_err", Error, 0);

        // Size 2 read of the top address.
        do_start(2'd1, 2'd2, 16'h1BFF, 16'h0000, 16'h8001, -1);
        wait_idle();
        chk("read10_data", ReadData, 16'h8001);
        chk("read10_pulses", dev_pulses, 29);

        // Size 1 read, then size code 3 behaving as size 2.
        do_start(2'd1, 2'd1, 16'h06A5, 16'h0000, 16'h5A3C, -1);
        wait_idle();
        chk("read8_data", ReadData, 16'h5A3C);
        do_start(2'd1, 2'd3, 16'h1A00, 16'h0000, 16'h0F0F, -1);
        wait_idle();
        chk("read_sz3_data", ReadData, 16'h0F0F);
        chk("read_sz3_pulses", dev_pulses, 29);

        // Reset during WROUT bit 5 (CMD is 36 cycles, each bit 4 cycles).
        do_start(2'd2, 2'd0, 16'h0155, 16'hC3A5, 16'h0000, 3);
        while (cyc < start_cyc + 57) @(negedge SClk);
        nRst = 1'b0;
        @(posedge SClk);
        #1;
        exp_q.delete();
        exp_rd  = 16'h0;
        exp_err = 1'b0;
        chk("midop_rst", {EepCS, EepSK, EepDI, Busy, Done, Error, ReadData}, 0);
        @(negedge SClk);
        nRst = 1'b1;
        repeat (2 * SKH + 2) @(negedge SClk);
        chk("midop_no_done", done_cyc, -1);

        do_start(2'd1, 2'd0, 16'h0183, 16'h0000, 16'h7E81, -1);
        wait_idle();
        chk("post_rst_read", ReadData, 16'h7E81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
